// File: rtl/ycc_conv_ctrl.sv
// Sequencer around the enable-driven RGB->YCbCr converter: tags in-flight
// pixels, flushes them with dummy enables and buffers results per 8x8 block.
module ycc_conv_ctrl #(
    parameter int OUT_DEPTH    = 8,
    parameter int BLOCK_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    input  logic        stop,
    output logic        conv_enable,
    output logic [23:0] conv_data_in,
    input  logic [23:0] conv_data_out,
    input  logic        conv_enable_out,
    output logic        ycc_valid,
    output logic [23:0] ycc_data,
    output logic        ycc_last,
    input  logic        ycc_ready,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam int PW = $clog2(BLOCK_PIXELS);
    localparam logic [PW-1:0] LAST_CNT = PW'(BLOCK_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    logic            v1;
    logic            v2;
    logic            v3;
    logic [24:0]     mem [OUT_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   pix_cnt;
    logic [SW-1:0]   reserved;
    logic            issue;
    logic            pop;
    logic            push;
    logic            pipe_empty;
    logic            drain_done;

    // FIFO slots already owned: stored entries plus pixels still in the converter
    assign reserved = SW'(count) - SW'(pop) + SW'(v1) + SW'(v2) + SW'(v3);

    assign pop          = ycc_valid & ycc_ready;
    assign push         = v3;
    assign pix_ready    = rst_n & (state != DRAIN) & (reserved < SW'(OUT_DEPTH));
    assign issue        = pix_valid & pix_ready;
    assign conv_enable  = issue | v1;
    assign conv_data_in = issue ? pix_data : 24'h0;
    assign ycc_valid    = (count != '0);
    assign ycc_data     = ycc_valid ? mem[rd_ptr][23:0] : 24'h0;
    assign ycc_last     = ycc_valid & mem[rd_ptr][24];
    assign pipe_empty   = !(v1 | v2 | v3) && (count == '0);
    assign drain_done   = (state == DRAIN) && pipe_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= drain_done;
            unique case (state)
                IDLE: begin
                    if (stop)       state <= DRAIN;
                    else if (issue) state <= RUN;
                end
                RUN: begin
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            err <= 1'b0;
        end else begin
            v1  <= issue;
            v2  <= v1;
            v3  <= v2;
            err <= err | (conv_enable_out != v3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pix_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drain_done) begin
                pix_cnt <= '0;
            end else if (push) begin
                pix_cnt <= (pix_cnt == LAST_CNT) ? '0 : pix_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pix_cnt == LAST_CNT, conv_data_out};
    end

endmodule

// File: tb/tb_ycc_conv_ctrl.sv
// Bench for ycc_conv_ctrl: behavioural converter plus an in-order
// scoreboard of expected YCbCr results and block-last flags.
module tb_ycc_conv_ctrl;

    localparam int BP = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        stop;
    logic        conv_enable;
    logic [23:0] conv_data_in;
    logic [23:0] conv_data_out;
    logic        conv_enable_out;
    logic        ycc_valid;
    logic [23:0] ycc_data;
    logic        ycc_last;
    logic        ycc_ready;
    logic        done;
    logic        err;
    logic        flip;

    int checks = 0;
    int failures = 0;

    logic [24:0] exp_q[$];
    int          acc_idx = 0;
    logic        stalled = 1'b0;
    logic [24:0] held;
    logic [24:0] mon_e;
    logic        mon_last;

    ycc_conv_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .stop            (stop),
        .conv_enable     (conv_enable),
        .conv_data_in    (conv_data_in),
        .conv_data_out   (conv_data_out),
        .conv_enable_out (conv_enable_out),
        .ycc_valid       (ycc_valid),
        .ycc_data        (ycc_data),
        .ycc_last        (ycc_last),
        .ycc_ready       (ycc_ready),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ycc(input logic [23:0] p);
        int r, g, b, y, cb, cr;
        r  = int'(p[7:0]);
        g  = int'(p[15:8]);
        b  = int'(p[23:16]);
        y  = (77 * r + 150 * g + 29 * b) >>> 8;
        cb = ((128 * b - 43 * r - 85 * g) >>> 8) + 128;
        cr = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
        if (y > 255) y = 255;
        if (cb > 255) cb = 255;
        if (cb < 0) cb = 0;
        if (cr > 255) cr = 255;
        if (cr < 0) cr = 0;
        return {cr[7:0], cb[7:0], y[7:0]};
    endfunction

    // Converter: two enable-gated stages, one free-running stage
    logic [23:0] s1, s2, s3;
    logic        t1, t2, t3;

    always @(posedge clk) begin
        if (conv_enable) begin
            s1 <= conv_data_in;
            s2 <= s1;
        end
        s3 <= s2;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= 1'b0;
            t2 <= 1'b0;
            t3 <= 1'b0;
        end else begin
            t1 <= pix_valid & pix_ready;
            t2 <= t1;
            t3 <= t2;
        end
    end

    assign conv_data_out   = ycc(s3);
    assign conv_enable_out = t3 ^ flip;

    // Scoreboard: expected results in acceptance order
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_idx = 0;
            stalled = 1'b0;
        end else begin
            if (done) acc_idx = 0;
            if (pix_valid && pix_ready) begin
                mon_last = ((acc_idx % BP) == BP - 1);
                exp_q.push_back({mon_last, ycc(pix_data)});
                acc_idx++;
            end
            if (stalled) begin
                checks++;
                if (!ycc_valid || {ycc_last, ycc_data} !== held) begin
                    failures++;
                    $display("FAIL hold: got v=%0b %h required %h",
                             ycc_valid, {ycc_last, ycc_data}, held);
                end
            end
            if (ycc_valid && ycc_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ycc_extra: got %h required none",
                             {ycc_last, ycc_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({ycc_last, ycc_data} !== mon_e) begin
                        failures++;
                        $display("FAIL ycc_out: got %h required %h",
                                 {ycc_last, ycc_data}, mon_e);
                    end
                end
            end
            stalled = ycc_valid && !ycc_ready;
            held    = {ycc_last, ycc_data};
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        stop      = 1'b0;
        flip      = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pix_valid = 1'b1;
        pix_data  = 24'($urandom);
        @(negedge clk);
        checks++;
        if ({pix_ready, conv_enable, ycc_valid, ycc_last, done, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {pix_ready, conv_enable, ycc_valid, ycc_last, done, err});
        end
        checks++;
        if (conv_data_in !== 24'h0) begin
            failures++;
            $display("FAIL reset_conv_data: got %h required 000000", conv_data_in);
        end
        checks++;
        if (ycc_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_ycc_data: got %h required 000000", ycc_data);
        end
        nxt();
        pix_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        ycc_ready = 1'b1;
        pix_data  = 24'h0;
        pix_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (pix_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL single_accept: got %b required 1", pix_ready);
                end
            end
            checks++;
            if (conv_enable !== 1'(k <= 1)) begin
                failures++;
                $display("FAIL single_en k=%0d: got %b required %b",
                         k, conv_enable, k <= 1);
            end
            checks++;
            if (ycc_valid !== 1'(k == 4)) begin
                failures++;
                $display("FAIL single_valid k=%0d: got %b required %b",
                         k, ycc_valid, k == 4);
            end
            if (k == 4) begin
                checks++;
                if (ycc_data !== 24'h808000) begin
                    failures++;
                    $display("FAIL single_data: got %h required 808000", ycc_data);
                end
            end
            nxt();
            pix_valid = 1'b0;
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL single_err: got %b required 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, outs = 0, drops = 0;
        int first = -1, lastc = -1, lasts = 0, last_pos = -1;
        do_reset();
        ycc_ready = 1'b1;
        pix_data  = 24'hFFFFFF;
        pix_valid = 1'b1;
        for (int c = 0; c < 120 && outs < 65; c++) begin
            @(negedge clk);
            if (pix_valid && !pix_ready) drops++;
            if (pix_valid && pix_ready) acc++;
            if (ycc_valid && ycc_ready) begin
                if (first < 0) first = c;
                lastc = c;
                if (ycc_last) begin
                    lasts++;
                    last_pos = outs;
                end
                outs++;
            end
            nxt();
            pix_valid = (acc < 65);
        end
        pix_valid = 1'b0;
        checks++;
        if (drops != 0) begin
            failures++;
            $display("FAIL b2b_drops: got %0d required 0", drops);
        end
        checks++;
        if (outs != 65) begin
            failures++;
            $display("FAIL b2b_outs: got %0d required 65", outs);
        end
        checks++;
        if (first != 4 || lastc - first != 64) begin
            failures++;
            $display("FAIL b2b_timing: got first=%0d span=%0d required 4 64",
                     first, lastc - first);
        end
        checks++;
        if (lasts != 1 || last_pos != 63) begin
            failures++;
            $display("FAIL b2b_last: got n=%0d pos=%0d required 1 63",
                     lasts, last_pos);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, outs = 0;
        logic a;
        logic rdy_end = 1'b1;
        ycc_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 24'($urandom);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a = pix_valid && pix_ready;
            if (a) acc++;
            rdy_end = pix_ready;
            nxt();
            if (a) pix_data = 24'($urandom);
        end
        checks++;
        if (acc != 8) begin
            failures++;
            $display("FAIL bp_accepted: got %0d required 8", acc);
        end
        checks++;
        if (rdy_end !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: got %b required 0", rdy_end);
        end
        ycc_ready = 1'b1;
        pix_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ycc_valid && ycc_ready) outs++;
            nxt();
        end
        checks++;
        if (outs != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_outs: got %0d left %0d required 8 left 0",
                     outs, exp_q.size());
        end
        pix_valid = 1'b1;
        pix_data  = 24'($urandom);
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume: got %b required 1", pix_ready);
        end
        nxt();
        pix_valid = 1'b0;
        repeat (10) nxt();
    endtask

    task automatic test_toggle();
        logic prev = 1'b0;
        logic cur;
        for (int c = 0; c < 40; c++) begin
            pix_valid = (c % 2 == 0);
            pix_data  = 24'($urandom);
            ycc_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (prev) begin
                checks++;
                if (conv_enable !== 1'b1 || conv_data_in !== 24'h0) begin
                    failures++;
                    $display("FAIL toggle_dummy: got en=%b d=%h required 1 000000",
                             conv_enable, conv_data_in);
                end
            end
            cur = pix_valid && pix_ready;
            if (cur) begin
                checks++;
                if (conv_enable !== 1'b1 || conv_data_in !== pix_data) begin
                    failures++;
                    $display("FAIL toggle_issue: got en=%b d=%h required 1 %h",
                             conv_enable, conv_data_in, pix_data);
                end
            end
            prev = cur;
            nxt();
        end
        pix_valid = 1'b0;
        ycc_ready = 1'b1;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || ycc_valid); c++) nxt();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL toggle_drain: got %0d left required 0", exp_q.size());
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL toggle_err: got %b required 0", err);
        end
    endtask

    task automatic test_stop();
        int acc = 0, outs = 0, dones = 0, leak = 0, bad = 0;
        int lasts = 0, last_pos = -1;
        ycc_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            pix_valid = (c < 2) || (c >= 3 && c <= 5);
            stop      = (c == 2) || (c == 4);
            pix_data  = 24'($urandom);
            @(negedge clk);
            if (pix_valid && pix_ready) acc++;
            if (c >= 3 && c <= 5 && pix_ready) leak++;
            if (ycc_valid && ycc_ready) outs++;
            if (done) begin
                dones++;
                if (ycc_valid || exp_q.size() != 0) bad++;
            end
            nxt();
        end
        pix_valid = 1'b0;
        stop      = 1'b0;
        checks++;
        if (acc != 2 || leak != 0) begin
            failures++;
            $display("FAIL stop_intake: got acc=%0d leak=%0d required 2 0", acc, leak);
        end
        checks++;
        if (outs != 2) begin
            failures++;
            $display("FAIL stop_outs: got %0d required 2", outs);
        end
        checks++;
        if (dones != 1 || bad != 0) begin
            failures++;
            $display("FAIL stop_done: got n=%0d early=%0d required 1 0", dones, bad);
        end
        acc  = 0;
        outs = 0;
        pix_valid = 1'b1;
        pix_data  = 24'($urandom);
        for (int c = 0; c < 150 && outs < BP; c++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) acc++;
            if (ycc_valid && ycc_ready) begin
                if (ycc_last) begin
                    lasts++;
                    last_pos = outs;
                end
                outs++;
            end
            nxt();
            pix_valid = (acc < BP);
            pix_data  = 24'($urandom);
        end
        pix_valid = 1'b0;
        checks++;
        if (outs != BP || lasts != 1 || last_pos != BP - 1) begin
            failures++;
            $display("FAIL stop_newblock: got outs=%0d n=%0d pos=%0d required 64 1 63",
                     outs, lasts, last_pos);
        end
        pix_valid = 1'b1;
        stop      = 1'b1;
        pix_data  = 24'($urandom);
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL stop_same_accept: got %b required 1", pix_ready);
        end
        nxt();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL stop_same_block: got %b required 0", pix_ready);
        end
        nxt();
        pix_valid = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
            nxt();
        end
        checks++;
        if (dones != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stop_same_done: got n=%0d left=%0d required 1 0",
                     dones, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0, stale = 0;
        logic a;
        logic [23:0] p;
        ycc_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 24'($urandom);
        for (int c = 0; c < 30 && acc < 8; c++) begin
            @(negedge clk);
            a = pix_valid && pix_ready;
            if (a) acc++;
            nxt();
            if (a) pix_data = 24'($urandom);
        end
        checks++;
        if (acc != 8 || ycc_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_fill: got acc=%0d v=%b required 8 1", acc, ycc_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_ready, conv_enable, ycc_valid, ycc_last, done, err} !== 6'b0) begin
            failures++;
            $display("FAIL rmid_ctrl: got %b required 000000",
                     {pix_ready, conv_enable, ycc_valid, ycc_last, done, err});
        end
        checks++;
        if (ycc_data !== 24'h0 || conv_data_in !== 24'h0) begin
            failures++;
            $display("FAIL rmid_data: got %h %h required 0 0", ycc_data, conv_data_in);
        end
        @(negedge clk);
        nxt();
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        ycc_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ycc_valid) stale++;
            nxt();
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rmid_stale: got %0d required 0", stale);
        end
        p = 24'($urandom);
        pix_data  = p;
        pix_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (ycc_valid !== 1'(k == 4)) begin
                failures++;
                $display("FAIL rmid_valid k=%0d: got %b required %b",
                         k, ycc_valid, k == 4);
            end
            if (k == 4) begin
                checks++;
                if (ycc_data !== ycc(p)) begin
                    failures++;
                    $display("FAIL rmid_data_out: got %h required %h", ycc_data, ycc(p));
                end
            end
            nxt();
            pix_valid = 1'b0;
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean: got %b required 0", err);
        end
        nxt();
        flip = 1'b1;
        nxt();
        flip = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: got %b required 1", err);
        end
        repeat (3) nxt();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        nxt();
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_reset: got %b required 0", err);
        end
        nxt();
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 24'h0;
        stop      = 1'b0;
        ycc_ready = 1'b1;
        flip      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_stop();
        test_reset_mid();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
